product_bcd_module: RTL and testbench
=====================================

// Module: product_bcd_module
// PURPOSE
//   Sequential signed-binary to sign+BCD converter; consumes the 16-bit two's-complement
//   Product of the 8x8 signed multiplier stage and produces a sign flag plus packed BCD
//   digits for the display/readout stage. Uses the same Start_Sig/Done_Sig handshake as
//   the multiplier: Start_Sig is held high for the whole conversion, and Done_Sig pulses for 1 cycle.
//   Conversion is iterative shift-add-3 (double dabble), one bit per clock.
// PARAMETERS
//   WIDTH   16  input width, two's complement; >= 2
//   DIGITS  5   BCD digits; must satisfy 10**DIGITS > 2**(WIDTH-1)
// PORTS
//   CLK        in   1           clock, rising edge
//   RSTn       in   1           asynchronous, active-low reset
//   Start_Sig  in   1           level: high = run/continue conversion; low = pause
//   Product_In in   WIDTH       two's-complement value; sampled in CAPTURE state only
//   Done_Sig   out  1           1-cycle pulse: conversion complete, outputs valid
//   Sign_Out   out  1           1 = value was negative
//   BCD_Out    out  4*DIGITS    packed BCD magnitude; digit 0 = [3:0] = least significant
// BEHAVIOUR
//   Reset (async, RSTn low): state=CAPTURE, bit counter=0, shift regs=0, Done_Sig=0,
//     Sign_Out=0, BCD_Out=0. Takes effect immediately, including mid-conversion;
//     a partial result is discarded.
//   All state advances only on CLK edges with Start_Sig=1.
//   When Start_Sig=0, all registers hold, including an asserted Done_Sig (pause semantics).
//   FSM (2-bit state i):
//     0 CAPTURE: sign <= Product_In[WIDTH-1]; mag <= sign ? (~Product_In+1) : Product_In
//                (WIDTH-bit unsigned; -2**(WIDTH-1) yields mag=2**(WIDTH-1), which is correct);
//                bcd_work <= 0; cnt <= 0; -> SHIFT
//     1 SHIFT:   each cycle: every bcd_work digit >=5 gets +3 (combinational),
//                then {bcd_work,mag} shifts left by 1; cnt <= cnt+1;
//                after exactly WIDTH shifts -> DONE
//     2 DONE:    BCD_Out <= bcd_work; Sign_Out <= sign; Done_Sig <= 1; -> CLEAR
//     3 CLEAR:   Done_Sig <= 0; -> CAPTURE
//   Latency: with Start_Sig held high, Done_Sig is high during the cycle after the
//     (WIDTH+2)th rising edge (1 CAPTURE + WIDTH SHIFT + 1 DONE). Done_Sig stays high
//     for exactly 1 cycle. Total period is WIDTH+3 cycles.
//   BCD_Out/Sign_Out update only in DONE. They hold their values until the next DONE,
//     so they are stable while Done_Sig=1 and afterwards.
//   Zero input: Sign_Out=0 and BCD_Out=0. There is no negative zero.
//   If Start_Sig remains high after CLEAR, a new conversion starts: Product_In is
//     resampled in CAPTURE. The upstream stage drops Start_Sig on Done_Sig.
//   Product_In changes outside CAPTURE have no effect.
//   The bit counter must not wrap: it is sized for WIDTH and is compared for equality.
// TESTING
//   1 Reset mid-SHIFT (RSTn low 1 cycle) -> Done_Sig=0, BCD_Out=0, Sign_Out=0 at once;
//     a restart with 16'd1234 -> BCD_Out=20'h01234.
//   2 Product_In=16'h0000 -> after 18 edges: Done_Sig=1 for 1 cycle, Sign_Out=0, BCD_Out=20'h00000.
//   3 Product_In=16'h7FFF -> Sign_Out=0, BCD_Out=20'h32767. Product_In=16'h8000 ->
//     Sign_Out=1, BCD_Out=20'h32768.
//   4 Product_In=16'hFF9C (-100) -> Sign_Out=1, BCD_Out=20'h00100.
//     Chained from the multiplier with -128*127 (16'hC080) -> Sign_Out=1, BCD_Out=20'h16256.
//   5 Start_Sig dropped for 5 cycles mid-SHIFT, then restored -> result is still correct
//     for 16'd9999 (20'h09999); Done_Sig is delayed by exactly 5 cycles.
//   6 Product_In toggles randomly after CAPTURE -> the result matches the value present
//     at CAPTURE. Random sweep of 1000 values vs reference model.

Source files
------------

// File: rtl/product_bcd_module.sv
// product_bcd_module
// Sequential two's-complement to sign + packed BCD converter. Magnitude is
// converted with shift-add-3 (double dabble), one input bit per clock, under
// the Start_Sig level / Done_Sig pulse handshake shared with the multiplier.
module product_bcd_module #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  Start_Sig,
  input  logic [WIDTH-1:0]      Product_In,
  output logic                  Done_Sig,
  output logic                  Sign_Out,
  output logic [4*DIGITS-1:0]   BCD_Out
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  // Counter value seen during the final shift cycle; compared for equality only
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DONE    = 2'd2,
    ST_CLEAR   = 2'd3
  } state_e;

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   mag_q,      mag_d;
  logic [BCD_W-1:0]   bcd_work_q, bcd_work_d;
  logic               sign_q,     sign_d;
  logic               done_q,     done_d;
  logic               sign_out_q, sign_out_d;
  logic [BCD_W-1:0]   bcd_out_q,  bcd_out_d;
  logic [BCD_W-1:0]   bcd_adj;

  // Add-3 correction: any working digit of 5 or more is bumped before the shift
  always_comb begin
    bcd_adj = bcd_work_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd_work_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_work_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Next-state and next-output logic; everything holds while Start_Sig is low
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    bcd_work_d = bcd_work_q;
    sign_d     = sign_q;
    done_d     = done_q;
    sign_out_d = sign_out_q;
    bcd_out_d  = bcd_out_q;

    if (Start_Sig) begin
      case (state_q)
        ST_CAPTURE: begin
          // Negating the most negative value wraps to 2**(WIDTH-1), which is
          // exactly the unsigned magnitude wanted
          sign_d     = Product_In[WIDTH-1];
          mag_d      = Product_In[WIDTH-1] ? ((~Product_In) + WIDTH'(1)) : Product_In;
          bcd_work_d = '0;
          cnt_d      = '0;
          state_d    = ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd_work_d = {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
          mag_d      = {mag_q[WIDTH-2:0], 1'b0};
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_SHIFT) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_out_d  = bcd_work_q;
          sign_out_d = sign_q;
          done_d     = 1'b1;
          state_d    = ST_CLEAR;
        end
        ST_CLEAR: begin
          done_d  = 1'b0;
          state_d = ST_CAPTURE;
        end
        default: begin
          state_d = ST_CAPTURE;
        end
      endcase
    end
  end

  // State and output registers; reset discards any conversion in flight
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_CAPTURE;
      cnt_q      <= '0;
      mag_q      <= '0;
      bcd_work_q <= '0;
      sign_q     <= 1'b0;
      done_q     <= 1'b0;
      sign_out_q <= 1'b0;
      bcd_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      bcd_work_q <= bcd_work_d;
      sign_q     <= sign_d;
      done_q     <= done_d;
      sign_out_q <= sign_out_d;
      bcd_out_q  <= bcd_out_d;
    end
  end

  assign Done_Sig = done_q;
  assign Sign_Out = sign_out_q;
  assign BCD_Out  = bcd_out_q;

endmodule

// File: tb/tb_product_bcd_module.sv
// tb_product_bcd_module
// Directed and randomized checks of the signed binary to sign + BCD converter
// against a decimal reference computed with plain integer arithmetic.
module tb_product_bcd_module;

  logic        CLK;
  logic        RSTn;
  logic        Start_Sig;
  logic [15:0] Product_In;
  logic        Done_Sig;
  logic        Sign_Out;
  logic [19:0] BCD_Out;

  int checks;
  int errors;

  product_bcd_module #(
    .WIDTH  (16),
    .DIGITS (5)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Start_Sig  (Start_Sig),
    .Product_In (Product_In),
    .Done_Sig   (Done_Sig),
    .Sign_Out   (Sign_Out),
    .BCD_Out    (BCD_Out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One comparison: counts it, and counts and reports a failure
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of |v| using division and remainder
  function automatic logic [19:0] ref_bcd(input logic [15:0] v);
    int          m;
    logic [19:0] r;
    m = v[15] ? (65536 - int'(v)) : int'(v);
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Runs one conversion from CAPTURE; scrambles Product_In after capture,
  // optionally pauses mid-shift for 5 cycles and/or holds Done_Sig by pausing
  task automatic conv(input string tag, input logic [15:0] val, input logic exp_sign,
                      input logic [19:0] exp_bcd, input int pause_at, input bit hold_done);
    int total;
    bit seen;
    total      = 0;
    seen       = 1'b0;
    Product_In = val;
    Start_Sig  = 1'b1;
    while (!seen && total < 60) begin
      @(posedge CLK);
      total++;
      @(negedge CLK);
      if (Done_Sig) begin
        seen = 1'b1;
      end else begin
        Product_In = 16'($urandom);
        if (total == pause_at) begin
          Start_Sig = 1'b0;
          repeat (5) begin
            @(posedge CLK);
            total++;
            @(negedge CLK);
          end
          chk({tag, "_pause_no_done"}, 32'(Done_Sig), 32'd0);
          Start_Sig = 1'b1;
        end
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(total), (pause_at > 0) ? 32'd23 : 32'd18);
    chk({tag, "_sign"}, 32'(Sign_Out), 32'(exp_sign));
    chk({tag, "_bcd"}, 32'(BCD_Out), 32'(exp_bcd));
    if (hold_done) begin
      Start_Sig = 1'b0;
      repeat (3) begin
        @(posedge CLK);
        @(negedge CLK);
      end
      chk({tag, "_done_held"}, 32'(Done_Sig), 32'd1);
      Start_Sig = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_done_pulse_end"}, 32'(Done_Sig), 32'd0);
    chk({tag, "_bcd_stable"}, 32'(BCD_Out), 32'(exp_bcd));
    chk({tag, "_sign_stable"}, 32'(Sign_Out), 32'(exp_sign));
  endtask

  initial begin
    logic [15:0] rv;
    checks     = 0;
    errors     = 0;
    RSTn       = 1'b0;
    Start_Sig  = 1'b0;
    Product_In = '0;
    repeat (3) @(negedge CLK);
    chk("reset_done", 32'(Done_Sig), 32'd0);
    chk("reset_sign", 32'(Sign_Out), 32'd0);
    chk("reset_bcd", 32'(BCD_Out), 32'd0);
    RSTn = 1'b1;

    // Zero, extremes, small negative, multiplier corner
    conv("zero",   16'h0000, 1'b0, 20'h00000, 0, 1'b0);
    conv("maxpos", 16'h7FFF, 1'b0, 20'h32767, 0, 1'b0);
    conv("maxneg", 16'h8000, 1'b1, 20'h32768, 0, 1'b0);
    conv("neg100", 16'hFF9C, 1'b1, 20'h00100, 0, 1'b0);
    conv("mulmin", 16'hC080, 1'b1, 20'h16256, 0, 1'b0);

    // Pause mid-shift, then pause while Done_Sig is asserted
    conv("pause9999", 16'd9999, 1'b0, 20'h09999, 6, 1'b1);

    // Establish a nonzero result, then reset mid-shift
    conv("neg5", 16'hFFFB, 1'b1, 20'h00005, 0, 1'b0);
    Product_In = 16'd4321;
    Start_Sig  = 1'b1;
    repeat (8) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    RSTn = 1'b0;
    #1;
    chk("midreset_done", 32'(Done_Sig), 32'd0);
    chk("midreset_sign", 32'(Sign_Out), 32'd0);
    chk("midreset_bcd", 32'(BCD_Out), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    conv("restart1234", 16'd1234, 1'b0, 20'h01234, 0, 1'b0);

    // Random sweep against the decimal reference
    for (int i = 0; i < 1000; i++) begin
      rv = 16'($urandom);
      conv("rand", rv, rv[15], ref_bcd(rv), 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
